// File: rtl/shadow_dump_sched.sv
// Purpose : capture a selected set of shadow chains, then dump them one at a time in ascending index order onto one serial port.
// Latency : c_en and d_en come straight from the state register; ser_out/ser_valid lag d_out/d_ready by 1 cycle.
// Backpressure: none. A chain ends its dump with d_done. If it has not, the timeout ends it after TIMEOUT cycles and flags err.
//
// Ports:
//   clk, rst (async active-low)   trig / dump_req / abort : control requests
//   sel_mask   : chains to capture and dump
//   c_en       : capture enables          d_en    : one-hot dump enable
//   d_out / d_ready / d_done : per-chain serial data, data valid, dump complete
//   ser_out / ser_valid / ser_idx : muxed serial stream and active chain
//   busy, all_done (1-cycle pulse), err (sticky per-chain timeout flags)
module shadow_dump_sched #(
    parameter int NUM_CHAINS  = 4,
    parameter int COUNT_WIDTH = 8,
    parameter int TIMEOUT     = 200,
    localparam int IDX_W      = (NUM_CHAINS > 1) ? $clog2(NUM_CHAINS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  trig,
    input  logic                  dump_req,
    input  logic                  abort,
    input  logic [NUM_CHAINS-1:0] sel_mask,
    output logic [NUM_CHAINS-1:0] c_en,
    output logic [NUM_CHAINS-1:0] d_en,
    input  logic [NUM_CHAINS-1:0] d_out,
    input  logic [NUM_CHAINS-1:0] d_ready,
    input  logic [NUM_CHAINS-1:0] d_done,
    output logic                  ser_out,
    output logic                  ser_valid,
    output logic [IDX_W-1:0]      ser_idx,
    output logic                  busy,
    output logic                  all_done,
    output logic [NUM_CHAINS-1:0] err
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CAPTURE = 3'd1;
    localparam logic [2:0] S_ARMED   = 3'd2;
    localparam logic [2:0] S_SELECT  = 3'd3;
    localparam logic [2:0] S_DUMP    = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    localparam logic [COUNT_WIDTH-1:0] CNT_LAST = COUNT_WIDTH'(TIMEOUT - 1);

    logic [2:0]             state;
    logic [2:0]             state_nxt;
    logic [NUM_CHAINS-1:0]  pend;
    logic [COUNT_WIDTH-1:0] cnt;
    logic [IDX_W-1:0]       sel_idx;
    logic                   chain_done;
    logic                   chain_timeout;
    logic                   trig_ok;

    // A trigger with an empty mask is treated as if it never happened.
    assign trig_ok       = trig && (|sel_mask);
    // Only the active chain's completion matters; the others are ignored.
    assign chain_done    = d_done[ser_idx];
    assign chain_timeout = (cnt == CNT_LAST);

    // Lowest-index pending chain. The loop runs downward so the lowest set bit is written last and wins.
    always_comb begin
        sel_idx = '0;
        for (int i = NUM_CHAINS - 1; i >= 0; i--) begin
            if (pend[i]) begin
                sel_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:    if (trig_ok) state_nxt = S_CAPTURE;
                S_CAPTURE: state_nxt = S_ARMED;
                S_ARMED: begin
                    if (trig_ok) begin
                        state_nxt = S_CAPTURE;
                    end else if (dump_req) begin
                        state_nxt = S_SELECT;
                    end
                end
                S_SELECT:  state_nxt = (|pend) ? S_DUMP : S_DONE;
                S_DUMP:    if (chain_done || chain_timeout) state_nxt = S_SELECT;
                S_DONE:    state_nxt = S_IDLE;
                default:   state_nxt = S_IDLE;
            endcase
        end
    end

    // Enables and status are decoded from the state register. Because of this, an
    // asynchronous reset drops d_en at once, without waiting for a clock edge. It
    // also means c_en and d_en can never both be active.
    assign c_en     = (state == S_CAPTURE) ? pend : '0;
    assign d_en     = (state == S_DUMP) ? (NUM_CHAINS'(1) << ser_idx) : '0;
    assign busy     = (state != S_IDLE);
    assign all_done = (state == S_DONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            pend      <= '0;
            cnt       <= '0;
            ser_idx   <= '0;
            ser_out   <= 1'b0;
            ser_valid <= 1'b0;
            err       <= '0;
        end else begin
            state <= state_nxt;

            // Register the data only while the dump continues into the next cycle.
            // This keeps ser_valid low in every cycle outside DUMP.
            if (state == S_DUMP && state_nxt == S_DUMP) begin
                ser_out   <= d_out[ser_idx];
                ser_valid <= d_ready[ser_idx];
            end else begin
                ser_out   <= 1'b0;
                ser_valid <= 1'b0;
            end

            if (abort) begin
                pend <= '0;
            end else begin
                case (state)
                    S_IDLE, S_ARMED: begin
                        // err is cleared on entry to CAPTURE, so it already reads 0 during the capture cycle.
                        if (trig_ok) begin
                            pend <= sel_mask;
                            err  <= '0;
                        end
                    end
                    S_SELECT: begin
                        if (|pend) begin
                            ser_idx <= sel_idx;
                            cnt     <= '0;
                        end
                    end
                    S_DUMP: begin
                        cnt <= cnt + COUNT_WIDTH'(1);
                        if (chain_done || chain_timeout) begin
                            pend[ser_idx] <= 1'b0;
                        end
                        // If done and timeout land on the same cycle, the chain counts as done.
                        if (chain_timeout && !chain_done) begin
                            err[ser_idx] <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
